// File: rtl/pipe_hazard_pkg.sv
// Shared types and default sizing for the pipeline hazard controller.
// Optional perf counters are enabled by defining HAZ_PERF_EN.
package pipe_hazard_pkg;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MD_WAIT = 1'b1
  } hz_state_t;

  localparam int HZ_REG_W      = 5;
  localparam int HZ_MD_TIMEOUT = 64;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: hazard inputs in, stall/flush enables out.
// stall_cnt/flush_cnt exist only when HAZ_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5
`ifdef HAZ_PERF_EN
  , parameter int CNT_W = 32
`endif
);

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             ex_is_muldiv;
  logic             md_done;
  logic             branch_taken;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_bubble;
  logic             md_start;
  logic             md_err;
`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  // Pipeline datapath / mul-div unit side.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_is_muldiv, md_done, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, md_start, md_err
`ifdef HAZ_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );

  // Hazard controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_is_muldiv, md_done, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, md_start, md_err
`ifdef HAZ_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_md_watchdog.sv
// Mul/div watchdog: clearable up-counter, expire_o high while count == MD_TIMEOUT-1.
// Combinational expire flag; clear has priority over enable.
module md_watchdog #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MD_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for PC, IF/ID and ID/EX; Mealy outputs (0-cycle), mul/div wait FSM.
// Optional stall/flush perf counters under HAZ_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_W      = HZ_REG_W,
  parameter int MD_TIMEOUT = HZ_MD_TIMEOUT
`ifdef HAZ_PERF_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic               clock,
  input  logic               reset_n,
  pipe_hazard_ctrl_if.slave  hz
);

  hz_state_t state_q, state_d;
  logic      md_err_q, md_err_d;
  logic      pc_w, ifid_w, idex_w, flush, bubble, start;
  logic      wd_clear, wd_en, wd_expire;
  logic      load_use;

  assign load_use = hz.ex_mem_read && (hz.ex_rt != {REG_W{1'b0}}) &&
                    ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  always_comb begin
    state_d  = state_q;
    md_err_d = md_err_q;
    pc_w     = 1'b1;
    ifid_w   = 1'b1;
    idex_w   = 1'b1;
    flush    = 1'b0;
    bubble   = 1'b0;
    start    = 1'b0;
    wd_clear = 1'b0;
    wd_en    = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (hz.branch_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (hz.ex_is_muldiv) begin
          start    = 1'b1;
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          idex_w   = 1'b0;
          wd_clear = 1'b1;
          state_d  = HZ_MD_WAIT;
        end else if (load_use) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bubble = 1'b1;
        end
      end
      HZ_MD_WAIT: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        idex_w = 1'b0;
        wd_en  = 1'b1;
        // Release on the done cycle so the result's instruction leaves EX at this edge.
        if (hz.md_done || wd_expire) begin
          pc_w    = 1'b1;
          ifid_w  = 1'b1;
          idex_w  = 1'b1;
          state_d = HZ_RUN;
          if (!hz.md_done) begin
            md_err_d = 1'b1;
          end
        end
      end
      default: state_d = HZ_RUN;
    endcase
    // Outputs must read as free-running while reset is held, regardless of inputs.
    if (!reset_n) begin
      pc_w   = 1'b1;
      ifid_w = 1'b1;
      idex_w = 1'b1;
      flush  = 1'b0;
      bubble = 1'b0;
      start  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HZ_RUN;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_err_q <= md_err_d;
    end
  end

  md_watchdog #(
    .MD_TIMEOUT (MD_TIMEOUT)
  ) u_md_watchdog (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (wd_clear),
    .enable_i (wd_en),
    .expire_o (wd_expire)
  );

  assign hz.pc_write    = pc_w;
  assign hz.ifid_write  = ifid_w;
  assign hz.idex_write  = idex_w;
  assign hz.ifid_flush  = flush;
  assign hz.idex_bubble = bubble;
  assign hz.md_start    = start;
  assign hz.md_err      = md_err_q;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs driven and outputs sampled in the clock low phase.
// With HAZ_PERF_EN defined the counters are built 4 bits wide so saturation is reachable.
module tb_pipe_hazard_ctrl;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   stalls;

  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(
    .REG_W (5)
`ifdef HAZ_PERF_EN
    , .CNT_W (4)
`endif
  ) hz ();

  pipe_hazard_ctrl #(
    .REG_W      (5),
    .MD_TIMEOUT (8)
`ifdef HAZ_PERF_EN
    , .CNT_W    (4)
`endif
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .hz      (hz)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Packed as {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, md_start}.
  function automatic logic [31:0] outs();
    return {26'd0, hz.pc_write, hz.ifid_write, hz.idex_write,
            hz.ifid_flush, hz.idex_bubble, hz.md_start};
  endfunction

  task automatic idle();
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0; hz.ex_mem_read = 1'b0;
    hz.ex_rt = '0; hz.ex_is_muldiv = 1'b0; hz.md_done = 1'b0; hz.branch_taken = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rt, input logic [4:0] rs);
    idle();
    hz.ex_mem_read = 1'b1; hz.ex_rt = rt; hz.id_rs = rs;
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  initial begin
    idle();
    // Reset held with hazard-causing inputs: outputs still forced to free-run.
    hz.branch_taken = 1'b1; hz.ex_is_muldiv = 1'b1;
    nxt(); #1;
    chk("reset_outs", outs(), 32'b111000);
    chk("reset_err", {31'd0, hz.md_err}, 32'd0);

    nxt(); reset_n = 1'b1; idle(); #1;
    chk("idle_run", outs(), 32'b111000);

    // Load-use via rs, then one-cycle only.
    nxt(); load_use(5'd5, 5'd5); #1;
    chk("lu_rs", outs(), 32'b001010);
    nxt(); idle(); #1;
    chk("lu_release", outs(), 32'b111000);
    // Load-use via rt.
    nxt(); load_use(5'd5, 5'd3); hz.id_uses_rt = 1'b1; hz.id_rt = 5'd5; #1;
    chk("lu_rt", outs(), 32'b001010);
    // Register 0 and unused rt never stall.
    nxt(); load_use(5'd0, 5'd0); #1;
    chk("lu_r0", outs(), 32'b111000);
    nxt(); load_use(5'd7, 5'd1); hz.id_rt = 5'd7; hz.id_uses_rt = 1'b0; #1;
    chk("lu_rt_unused", outs(), 32'b111000);
    // Branch beats a simultaneous load-use.
    nxt(); load_use(5'd5, 5'd5); hz.branch_taken = 1'b1; #1;
    chk("branch_prio", outs(), 32'b111110);
    // md_done in RUN is ignored.
    nxt(); idle(); hz.md_done = 1'b1; #1;
    chk("done_in_run", outs(), 32'b111000);

    // Mul/div: start cycle + 4 wait cycles stalled, released on the done cycle.
    nxt(); idle(); hz.ex_is_muldiv = 1'b1; #1;
    chk("md_start", outs(), 32'b000001);
    for (int i = 0; i < 4; i++) begin
      nxt();
      hz.branch_taken = (i == 1); hz.ex_mem_read = (i == 1); hz.ex_rt = 5'd5; hz.id_rs = 5'd5;
      #1;
      chk($sformatf("md_wait%0d", i), outs(), 32'b000000);
    end
    nxt(); idle(); hz.ex_is_muldiv = 1'b1; hz.md_done = 1'b1; #1;
    chk("md_done_release", outs(), 32'b111000);

    // Back-to-back mul/div that never completes: watchdog expires.
    stalls = 0;
    nxt(); idle(); hz.ex_is_muldiv = 1'b1; #1;
    chk("b2b_start", outs(), 32'b000001);
    for (int i = 0; i < 12 && hz.pc_write == 1'b0; i++) begin
      if (hz.pc_write == 1'b0) stalls++;
      nxt(); #1;
    end
    chk("wd_stall_cycles", stalls, 32'd8);
    chk("wd_release", outs(), 32'b111000);
    chk("wd_err_not_yet", {31'd0, hz.md_err}, 32'd0);
    nxt(); load_use(5'd9, 5'd9); #1;
    chk("wd_err_set", {31'd0, hz.md_err}, 32'd1);
    chk("wd_back_in_run", outs(), 32'b001010);
    nxt(); idle(); #1;
    chk("wd_err_sticky", {31'd0, hz.md_err}, 32'd1);

`ifdef HAZ_PERF_EN
    for (int i = 0; i < 20; i++) begin
      nxt(); load_use(5'd4, 5'd4); hz.branch_taken = (i >= 2);
    end
    nxt(); idle(); #1;
    chk("stall_sat", {28'd0, hz.stall_cnt}, 32'd15);
    chk("flush_sat", {28'd0, hz.flush_cnt}, 32'd15);
`endif

    // Async reset while in MD_WAIT.
    nxt(); idle(); hz.ex_is_muldiv = 1'b1;
    nxt(); #1;
    chk("pre_reset_wait", outs(), 32'b000000);
    reset_n = 1'b0; #1;
    chk("rst_in_wait_outs", outs(), 32'b111000);
    chk("rst_in_wait_err", {31'd0, hz.md_err}, 32'd0);
`ifdef HAZ_PERF_EN
    chk("rst_stall_cnt", {28'd0, hz.stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {28'd0, hz.flush_cnt}, 32'd0);
`endif
    nxt(); reset_n = 1'b1; idle(); #1;
    chk("post_reset_run", outs(), 32'b111000);
    nxt(); #1;
    chk("post_reset_err", {31'd0, hz.md_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
